// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one RAM port among NREQ requesters. It registers the winning
// access onto the port and returns read data to its owner through a two-stage tag pipeline.
module bram_port_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ-1:0]          i_r_w,
    input  logic [NREQ-1:0]          i_lock,
    input  logic [NREQ*AWIDTH-1:0]   i_addr,
    input  logic [NREQ*DWIDTH-1:0]   i_datain,
    output logic [NREQ-1:0]          o_gnt,
    output logic [NREQ-1:0]          o_rvalid,
    output logic [DWIDTH-1:0]        o_rdata,
    output logic                     o_ram_ce,
    output logic [AWIDTH-1:0]        o_ram_addr,
    output logic [DWIDTH-1:0]        o_ram_datain,
    output logic                     o_ram_r_w,
    input  logic [DWIDTH-1:0]        i_ram_dataout
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    function automatic idx_t next_idx(input idx_t k);
        if (32'(k) == NREQ - 1) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

    state_e              state_q, state_d;
    idx_t                owner_q, owner_d;
    idx_t                rr_q, rr_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   data_q, data_d;
    logic                rw_q, rw_d;
    logic                t1v_q, t1v_d;
    idx_t                t1i_q, t1i_d;
    logic                t2v_q, t2v_d;
    idx_t                t2i_q, t2i_d;

    logic                found;
    logic                gnt_en;
    idx_t                win;
    idx_t                cand;

    // Winner selection: locked owner only, otherwise scan upward from the rr pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        if (state_q == StLocked) begin
            if (i_req[owner_q]) begin
                found = 1'b1;
                win   = owner_q;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = idx_t'((32'(rr_q) + i) % NREQ);
                if (!found && i_req[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    assign gnt_en = ce & reset_n & found;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = 1'b0;
        t1v_d   = gnt_en & ~i_r_w[win];
        t1i_d   = win;
        t2v_d   = t1v_q;
        t2i_d   = t1i_q;
        if (gnt_en) begin
            addr_d = i_addr[32'(win)*AWIDTH +: AWIDTH];
            data_d = i_datain[32'(win)*DWIDTH +: DWIDTH];
            rw_d   = i_r_w[win];
            unique case (state_q)
                StIdle: begin
                    rr_d = next_idx(win);
                    if (i_lock[win]) begin
                        state_d = StLocked;
                        owner_d = win;
                    end
                end
                StLocked: begin
                    if (!i_lock[win]) begin
                        state_d = StIdle;
                        rr_d    = next_idx(owner_q);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            t1v_q   <= 1'b0;
            t1i_q   <= '0;
            t2v_q   <= 1'b0;
            t2i_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            t1v_q   <= t1v_d;
            t1i_q   <= t1i_d;
            t2v_q   <= t2v_d;
            t2i_q   <= t2i_d;
        end
    end

    always_comb begin
        o_gnt    = '0;
        o_rvalid = '0;
        if (gnt_en) begin
            o_gnt = {{(NREQ-1){1'b0}}, 1'b1} << win;
        end
        if (t2v_q) begin
            o_rvalid = {{(NREQ-1){1'b0}}, 1'b1} << t2i_q;
        end
    end

    assign o_rdata      = i_ram_dataout;
    assign o_ram_ce     = ce;
    assign o_ram_addr   = addr_q;
    assign o_ram_datain = data_q;
    assign o_ram_r_w    = rw_q;

endmodule
